and_nand_nor_2: RTL and testbench
=================================

AND_NAND_NOR_2 -- requirements
Module: and_nand_nor_2

Interface
REQ-001 Parameter WIDTH, default 1; bit width of operands and every result bus.
REQ-002 Port clk, input, 1; single clock, all state updates on its rising edge.
REQ-003 Port rst, input, 1; reset, asynchronous and active-high.
REQ-004 Port in_valid, input, 1; operand pair a/b valid this cycle.
REQ-005 Port a, input, WIDTH; operand A.
REQ-006 Port b, input, WIDTH; operand B.
REQ-007 Port op, input, 2 (gate_op_t); result selected onto y_sel.
REQ-008 Port out_valid, output, 1; registered results valid.
REQ-009 Port y_and, output, WIDTH; registered a & b.
REQ-010 Port y_nand, output, WIDTH; registered ~(a & b).
REQ-011 Port y_nor, output, WIDTH; registered ~(a | b).
REQ-012 Port y_sel, output, WIDTH; registered result chosen by op.
REQ-013 Port err, output, 1; sticky consistency-error flag, present only with the configuration macro defined.

Function
REQ-014 Each result bit is computed bitwise and independently; no carries or cross-bit terms.
REQ-015 The op encoding is: 2'b00 AND, 2'b01 NAND, 2'b10 NOR, 2'b11 reserved, which drives y_sel to all zeros.
REQ-016 Latency is exactly one clock: an edge with in_valid=1 registers all four results and sets out_valid=1 in the same update.
REQ-017 An edge with in_valid=0 holds y_and, y_nand, y_nor and y_sel at their previous values and clears out_valid to 0.
REQ-018 Back-to-back valid inputs produce back-to-back valid outputs; throughput is one operand pair per cycle and there is no stall or backpressure.
REQ-019 X or Z inputs are not masked; outputs follow the bitwise operators.
REQ-020 All-zero operands yield y_and=0, y_nand=all ones, y_nor=all ones.
REQ-021 All-one operands yield y_and=all ones, y_nand=0, y_nor=0.

Reset
REQ-022 Asserting rst immediately, without waiting for a clock edge, forces out_valid=0, y_and=0, y_nand=0, y_nor=0, y_sel=0 and err=0.
REQ-023 While rst is high, in_valid is ignored.
REQ-024 The first edge after rst deasserts behaves as a normal cycle.
REQ-025 A reset asserted mid-stream discards any result still in flight.

Configuration
REQ-026 The macro AND_NAND_NOR_2_CHECK_EN enables an internal consistency checker.
REQ-027 With the macro defined, on every cycle where out_valid=1 the checker verifies y_nand == ~y_and and (y_nor & y_and) == 0.
REQ-028 With the macro defined, any checker violation sets err to 1, and err stays at 1 until rst.
REQ-029 Without the macro, the err port and the checker logic are absent; all other behaviour is identical.

Structure
REQ-030 Package and_nand_nor_2_pkg holds the gate_op_t enum (OP_AND, OP_NAND, OP_NOR, OP_RSVD) and the DEFAULT_WIDTH=1 constant.
REQ-031 Sub-module gate2_cell is a purely combinational single-bit cell producing the and, nand and nor results.
REQ-032 gate2_cell is instantiated WIDTH times through a generate loop.
REQ-033 Registers, op selection and the checker reside in the top module.

Verification
REQ-034 WIDTH=1 truth table: drive each pair (a,b) = 00, 01, 10, 11 with in_valid=1 and check one cycle later:
- y_and = 0, 0, 0, 1
- y_nand = 1, 1, 1, 0
- y_nor = 1, 0, 0, 0
REQ-035 op sweep with a=1, b=0: y_sel must be 0, 1, 0 for op 00, 01, 10, and 0 for op 11.
REQ-036 Random: 10 cycles of random a/b with in_valid=1; each output must equal the bitwise reference of the previous cycle's inputs.
REQ-037 Hold: set in_valid=0 after a=1, b=1; out_valid must drop to 0 and y_and must stay 1.
REQ-038 Async reset: raise rst between clock edges; all outputs must read 0 before the next edge.
REQ-039 WIDTH=8 with a=8'hF0, b=8'h3C: y_and=8'h30, y_nand=8'hCF, y_nor=8'h03; with AND_NAND_NOR_2_CHECK_EN defined, err must stay 0.

Source files
------------

// File: rtl/and_nand_nor_2_pkg.sv
// Shared types and constants for the and_nand_nor_2 registered gate block.
// Optional checker is enabled by defining AND_NAND_NOR_2_CHECK_EN.
package and_nand_nor_2_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_NAND = 2'b01,
    OP_NOR  = 2'b10,
    OP_RSVD = 2'b11
  } gate_op_t;

  localparam int DEFAULT_WIDTH = 1;

endpackage : and_nand_nor_2_pkg

// File: rtl/and_nand_nor_2_gate2_cell.sv
// Single-bit combinational cell: AND, NAND and NOR of one operand bit pair.
module gate2_cell (
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_nand,
  output logic y_nor
);

  assign y_and  = a & b;
  assign y_nand = ~(a & b);
  assign y_nor  = ~(a | b);

endmodule : gate2_cell

// File: rtl/and_nand_nor_2.sv
// Registered bitwise AND/NAND/NOR with an op-selected result, one-cycle latency.
// Defining AND_NAND_NOR_2_CHECK_EN adds a sticky consistency checker on port err.
module and_nand_nor_2
  import and_nand_nor_2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_nand,
  output logic [WIDTH-1:0] y_nor,
  output logic [WIDTH-1:0] y_sel
`ifdef AND_NAND_NOR_2_CHECK_EN
  ,
  output logic             err
`endif
);

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] nand_w;
  logic [WIDTH-1:0] nor_w;
  logic [WIDTH-1:0] sel_w;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] y_and_d,  y_and_q;
  logic [WIDTH-1:0] y_nand_d, y_nand_q;
  logic [WIDTH-1:0] y_nor_d,  y_nor_q;
  logic [WIDTH-1:0] y_sel_d,  y_sel_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gate2_cell u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .y_and  (and_w[i]),
      .y_nand (nand_w[i]),
      .y_nor  (nor_w[i])
    );
  end

  // Reserved op code deliberately yields zero rather than a gate result.
  always_comb begin
    sel_w = '0;
    case (gate_op_t'(op))
      OP_AND:  sel_w = and_w;
      OP_NAND: sel_w = nand_w;
      OP_NOR:  sel_w = nor_w;
      OP_RSVD: sel_w = '0;
      default: sel_w = '0;
    endcase
  end

  always_comb begin
    out_valid_d = in_valid;
    y_and_d     = y_and_q;
    y_nand_d    = y_nand_q;
    y_nor_d     = y_nor_q;
    y_sel_d     = y_sel_q;
    if (in_valid) begin
      y_and_d  = and_w;
      y_nand_d = nand_w;
      y_nor_d  = nor_w;
      y_sel_d  = sel_w;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_and_q     <= '0;
      y_nand_q    <= '0;
      y_nor_q     <= '0;
      y_sel_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_and_q     <= y_and_d;
      y_nand_q    <= y_nand_d;
      y_nor_q     <= y_nor_d;
      y_sel_q     <= y_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y_and     = y_and_q;
  assign y_nand    = y_nand_q;
  assign y_nor     = y_nor_q;
  assign y_sel     = y_sel_q;

`ifdef AND_NAND_NOR_2_CHECK_EN
  logic err_d, err_q;
  logic bad_w;

  // Registered results must be mutually consistent whenever they are valid.
  always_comb begin
    bad_w = 1'b0;
    if (out_valid_q) begin
      bad_w = (y_nand_q != ~y_and_q) || ((y_nor_q & y_and_q) != '0);
    end
    err_d = err_q | bad_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule : and_nand_nor_2

// File: tb/tb_and_nand_nor_2.sv
// Directed bench for and_nand_nor_2 at WIDTH=1 and WIDTH=8 sharing one clock.
module tb_and_nand_nor_2;
  import and_nand_nor_2_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] op;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic       ov1, yand1, ynand1, ynor1, ysel1;
  logic       ov8;
  logic [7:0] yand8, ynand8, ynor8, ysel8;
`ifdef AND_NAND_NOR_2_CHECK_EN
  logic       err1, err8;
`endif

  int checks = 0;
  int errors = 0;

  and_nand_nor_2 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .op(op),
    .out_valid(ov1), .y_and(yand1), .y_nand(ynand1), .y_nor(ynor1), .y_sel(ysel1)
`ifdef AND_NAND_NOR_2_CHECK_EN
    , .err(err1)
`endif
  );

  and_nand_nor_2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .op(op),
    .out_valid(ov8), .y_and(yand8), .y_nand(ynand8), .y_nor(ynor8), .y_sel(ysel8)
`ifdef AND_NAND_NOR_2_CHECK_EN
    , .err(err8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_and_tt  = 4'b1000;  // index = {a,b}
  logic [3:0] exp_nand_tt = 4'b0111;
  logic [3:0] exp_nor_tt  = 4'b0001;
  logic [3:0] exp_sel_op  = 4'b0010;  // index = op, a=1 b=0

  logic [7:0] ra, rb;

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 2'b00;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    #12;
    check("rst_ov1", {7'd0, ov1}, 8'h00);
    check("rst_and1", {7'd0, yand1}, 8'h00);
    check("rst_nand1", {7'd0, ynand1}, 8'h00);
    check("rst_nor1", {7'd0, ynor1}, 8'h00);
    check("rst_nand8", ynand8, 8'h00);
    check("rst_sel8", ysel8, 8'h00);
    rst = 1'b0;

    // Truth table, back-to-back valid inputs.
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0]; op = OP_AND; in_valid = 1'b1;
      tick();
      check($sformatf("tt_ov_%0d", i), {7'd0, ov1}, 8'h01);
      check($sformatf("tt_and_%0d", i), {7'd0, yand1}, {7'd0, exp_and_tt[i]});
      check($sformatf("tt_nand_%0d", i), {7'd0, ynand1}, {7'd0, exp_nand_tt[i]});
      check($sformatf("tt_nor_%0d", i), {7'd0, ynor1}, {7'd0, exp_nor_tt[i]});
      check($sformatf("tt_sel_%0d", i), {7'd0, ysel1}, {7'd0, exp_and_tt[i]});
    end

    // Op sweep with a=1, b=0.
    for (int o = 0; o < 4; o++) begin
      a1 = 1'b1; b1 = 1'b0; op = o[1:0]; in_valid = 1'b1;
      tick();
      check($sformatf("op_sel_%0d", o), {7'd0, ysel1}, {7'd0, exp_sel_op[o]});
    end

    // Random 8-bit operands, reference is the bitwise definition.
    op = OP_NAND;
    for (int r = 0; r < 10; r++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      a8 = ra; b8 = rb; in_valid = 1'b1;
      tick();
      check($sformatf("rnd_and_%0d", r), yand8, ra & rb);
      check($sformatf("rnd_nand_%0d", r), ynand8, ~(ra & rb));
      check($sformatf("rnd_nor_%0d", r), ynor8, ~(ra | rb));
      check($sformatf("rnd_sel_%0d", r), ysel8, ~(ra & rb));
    end

    // Directed 8-bit vector, NOR selected.
    a8 = 8'hF0; b8 = 8'h3C; op = OP_NOR; in_valid = 1'b1;
    tick();
    check("w8_and", yand8, 8'h30);
    check("w8_nand", ynand8, 8'hCF);
    check("w8_nor", ynor8, 8'h03);
    check("w8_sel", ysel8, 8'h03);
    check("w8_ov", {7'd0, ov8}, 8'h01);

    // All-zero and all-one operands.
    a8 = 8'h00; b8 = 8'h00; op = OP_AND;
    tick();
    check("zero_and", yand8, 8'h00);
    check("zero_nand", ynand8, 8'hFF);
    check("zero_nor", ynor8, 8'hFF);
    a8 = 8'hFF; b8 = 8'hFF;
    tick();
    check("ones_and", yand8, 8'hFF);
    check("ones_nand", ynand8, 8'h00);
    check("ones_nor", ynor8, 8'h00);

    // Hold: in_valid low keeps results, drops out_valid.
    a1 = 1'b1; b1 = 1'b1; op = OP_AND; in_valid = 1'b1;
    tick();
    check("hold_pre_and", {7'd0, yand1}, 8'h01);
    in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00; op = OP_NOR;
    tick();
    check("hold_ov1", {7'd0, ov1}, 8'h00);
    check("hold_and1", {7'd0, yand1}, 8'h01);
    check("hold_sel1", {7'd0, ysel1}, 8'h01);
    check("hold_and8", yand8, 8'hFF);
    check("hold_ov8", {7'd0, ov8}, 8'h00);

`ifdef AND_NAND_NOR_2_CHECK_EN
    check("err1", {7'd0, err1}, 8'h00);
    check("err8", {7'd0, err8}, 8'h00);
`endif

    // Async reset between edges with a result present.
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b1; b1 = 1'b1; op = OP_NAND; in_valid = 1'b1;
    tick();
    check("pre_rst_nand8", ynand8, 8'hFF);
    #2 rst = 1'b1;
    #1;
    check("arst_ov1", {7'd0, ov1}, 8'h00);
    check("arst_and1", {7'd0, yand1}, 8'h00);
    check("arst_nand8", ynand8, 8'h00);
    check("arst_nor8", ynor8, 8'h00);
    check("arst_sel8", ysel8, 8'h00);
    tick();
    check("rst_ign_ov8", {7'd0, ov8}, 8'h00);
    check("rst_ign_nand8", ynand8, 8'h00);
    rst = 1'b0;
    a8 = 8'h0F; b8 = 8'h05; op = OP_AND;
    tick();
    check("post_rst_ov8", {7'd0, ov8}, 8'h01);
    check("post_rst_and8", yand8, 8'h05);
    check("post_rst_nor8", ynor8, 8'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_and_nand_nor_2
